// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit ALU: operation classes, opcodes, number modes.
package alu_pkg;

  localparam int unsigned DW = 32;

  // Operation class (A_or_L)
  localparam logic CLS_ARITH = 1'b0;
  localparam logic CLS_LOGIC = 1'b1;

  // Arithmetic group opcodes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Logic group opcodes
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Number mode (S_or_U)
  localparam logic MODE_U = 1'b0;
  localparam logic MODE_S = 1'b1;

endpackage

// File: rtl/alu_divider.sv
// Combinational 32-bit quotient, unsigned (floor) or signed (truncate toward zero).
// Divide by zero returns all ones; INT_MIN / -1 wraps to INT_MIN.
module alu_divider
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          is_signed,
  output logic [DW-1:0] quotient
);

  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;
  logic [DW-1:0] q_mag;

  // Sign-magnitude division: divide magnitudes unsigned, then restore the sign.
  // INT_MIN / -1 falls out naturally: |INT_MIN| is 0x8000_0000, signs match, no negation.
  always_comb begin
    a_neg    = is_signed & a[DW-1];
    b_neg    = is_signed & b[DW-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    q_mag    = (b_mag == '0) ? '0 : (a_mag / b_mag);
    quotient = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    if (b == '0) begin
      quotient = '1;
    end
  end

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU: arithmetic/logic groups, combinational result, one-cycle registered output.
module alu
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  output logic [DW-1:0] answer,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          A_or_L,
  input  logic          S_or_U,
  input  logic [1:0]    OpCode
);

  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] b_ext;
  logic [DW-1:0]   mul_res;
  logic [DW-1:0]   div_q;
  logic [DW-1:0]   answer_d;
  logic [DW-1:0]   answer_q;

  alu_divider u_div (
    .a         (A),
    .b         (B),
    .is_signed (S_or_U == MODE_S),
    .quotient  (div_q)
  );

  // Multiplier: operands extended per mode; only the low product word is kept.
  always_comb begin
    a_ext   = (S_or_U == MODE_S) ? {{DW{A[DW-1]}}, A} : {{DW{1'b0}}, A};
    b_ext   = (S_or_U == MODE_S) ? {{DW{B[DW-1]}}, B} : {{DW{1'b0}}, B};
    mul_res = DW'(a_ext * b_ext);
  end

  // Result mux across adder/subtractor, multiplier, divider and logic unit.
  always_comb begin
    answer_d = '0;
    if (A_or_L == CLS_ARITH) begin
      case (OpCode)
        OP_ADD:  answer_d = A + B;
        OP_SUB:  answer_d = A - B;
        OP_MUL:  answer_d = mul_res;
        default: answer_d = div_q;
      endcase
    end else begin
      case (OpCode)
        OP_AND:  answer_d = A & B;
        OP_OR:   answer_d = A | B;
        OP_XOR:  answer_d = A ^ B;
        default: answer_d = ~(A | B);
      endcase
    end
  end

  // Output register, reloaded every edge; synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      answer_q <= '0;
    end else begin
      answer_q <= answer_d;
    end
  end

  assign answer = answer_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expected results, monitor pops one per edge.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] answer;
  logic [31:0] A;
  logic [31:0] B;
  logic        A_or_L;
  logic        S_or_U;
  logic [1:0]  OpCode;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  bit   stim_done = 0;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .answer (answer),
    .A      (A),
    .B      (B),
    .A_or_L (A_or_L),
    .S_or_U (S_or_U),
    .OpCode (OpCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the operation rules, using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic al, input logic su, input logic [1:0] op);
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (al) begin
      case (op)
        2'd0: return a & b;
        2'd1: return a | b;
        2'd2: return a ^ b;
        default: return ~(a | b);
      endcase
    end
    case (op)
      2'd0: begin ur = ua + ub; return ur[31:0]; end
      2'd1: begin ur = ua - ub; return ur[31:0]; end
      2'd2: begin
        if (su) begin sr = sa * sb; return sr[31:0]; end
        else begin ur = ua * ub; return ur[31:0]; end
      end
      default: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (su) begin sr = sa / sb; return sr[31:0]; end
        else begin ur = ua / ub; return ur[31:0]; end
      end
    endcase
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic issue(input string name, input logic rst, input logic [31:0] a,
                       input logic [31:0] b, input logic al, input logic su,
                       input logic [1:0] op, input logic [31:0] req);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    A      = a;
    B      = b;
    A_or_L = al;
    S_or_U = su;
    OpCode = op;
    e.name = name;
    e.exp  = req;
    exp_q.push_back(e);
  endtask

  // Same as issue, with the expectation taken from the reference model.
  task automatic issue_ref(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic al, input logic su, input logic [1:0] op);
    issue(name, 1'b0, a, b, al, su, op, ref_alu(a, b, al, su, op));
  endtask

  // Monitor: one result per edge, compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (answer === e.exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, answer, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic        ral, rsu;
    reset = 1'b1; A = '0; B = '0; A_or_L = 1'b0; S_or_U = 1'b0; OpCode = 2'b00;

    issue("reset", 1'b1, 32'h1234_5678, 32'h9, 1'b0, 1'b0, 2'b00, 32'h0);
    issue("add_62_15", 1'b0, 32'd62, 32'd15, 1'b0, 1'b0, 2'b00, 32'd77);
    issue("add_hold", 1'b0, 32'd62, 32'd15, 1'b0, 1'b0, 2'b00, 32'd77);
    issue("umul_5_3", 1'b0, 32'd5, 32'd3, 1'b0, 1'b0, 2'b10, 32'd15);
    issue("udiv_61_11", 1'b0, 32'd61, 32'd11, 1'b0, 1'b0, 2'b11, 32'd5);
    issue("udiv_b2b", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, 2'b11, 32'd14);
    issue("ssub_3_5", 1'b0, 32'd3, 32'd5, 1'b0, 1'b1, 2'b01, 32'hFFFF_FFFE);
    issue("smul_m4_6", 1'b0, 32'hFFFF_FFFC, 32'd6, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFE8);
    issue("sdiv_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFD);
    issue("udiv_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 2'b11, 32'h7FFF_FFFC);
    issue("sdiv_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFD);
    issue("udiv_by0", 1'b0, 32'd123, 32'd0, 1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF);
    issue("sdiv_by0", 1'b0, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF);
    issue("sdiv_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b11, 32'h8000_0000);
    issue("udiv_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b11, 32'h0);
    issue("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b00, 32'h0);
    for (int s = 0; s < 2; s++) begin
      issue("and", 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 1'(s), 2'b00, 32'h00F0_000F);
      issue("or",  1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 1'(s), 2'b01, 32'hFFF0_0FFF);
      issue("xor", 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 1'(s), 2'b10, 32'hFF00_0FF0);
      issue("nor", 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 1'(s), 2'b11, 32'h000F_F000);
    end
    // Reset in the middle of a divide stream
    issue("div_pre_rst", 1'b0, 32'd90, 32'd9, 1'b0, 1'b0, 2'b11, 32'd10);
    issue("div_in_rst", 1'b1, 32'd91, 32'd7, 1'b0, 1'b0, 2'b11, 32'h0);
    issue("div_post_rst", 1'b0, 32'd92, 32'd4, 1'b0, 1'b0, 2'b11, 32'd23);

    // Randomized operations; operands occasionally forced to corner values.
    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = $urandom_range(1, 16);
        default: ;
      endcase
      ral = 1'($urandom_range(0, 1));
      rsu = 1'($urandom_range(0, 1));
      rop = 2'($urandom_range(0, 3));
      issue_ref("random", ra, rb, ral, rsu, rop);
    end

    // Let the last queued result drain, bounded by a cycle budget.
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    #2;
    stim_done = 1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
